// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Instruction-memory request/response bundle between the fetch unit and
// instruction memory. Word-addressed, one outstanding request at a time.
//
// Signals:
//   imem_req    fetch request valid (driven by the fetch unit)
//   imem_addr   fetch word address, stable while imem_req=1 until ack
//   imem_ack    response valid this cycle (driven by memory); may arrive in
//               the same cycle as the request
//   imem_rdata  instruction word, valid with imem_ack
//
// Modports:
//   master  fetch unit side
//   slave   instruction memory side
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Instruction-fetch front end. Owns the program counter, issues word-addressed
// requests to instruction memory (one outstanding at most) and loads the IF/ID
// pipeline register. Accepts branch/jump redirects and stall back-pressure.
//
// Parameters:
//   RESET_PC          word address of the first fetch after reset
//
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   i_stall           decode cannot accept; freeze IF/ID and PC
//   i_branch_taken    redirect to i_branch_target (highest priority)
//   i_branch_target   branch destination word address
//   i_jump            redirect to i_jump_target (ignored with branch)
//   i_jump_target     jump destination word address
//   imem              instruction-memory bundle (master side)
//   o_if_id_pc1       address of captured instruction + 1
//   o_if_id_instr     captured instruction
//   o_if_id_valid     IF/ID holds a live instruction
//   o_fetch_count     (FETCH_PERF_CNT_EN only) count of valid IF/ID loads
//
// Optional feature macro: FETCH_PERF_CNT_EN adds o_fetch_count.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_stall,
  input  logic                i_branch_taken,
  input  logic [31:0]         i_branch_target,
  input  logic                i_jump,
  input  logic [31:0]         i_jump_target,
  pc_fetch_unit_if.master     imem,
  output logic [31:0]         o_if_id_pc1,
  output logic [31:0]         o_if_id_instr,
  output logic                o_if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         o_fetch_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_stale_addr;   // address of the abandoned request while draining
  logic [31:0] r_skid;         // response captured while decode was stalled
  logic [31:0] r_if_id_pc1;
  logic [31:0] r_if_id_instr;
  logic        r_if_id_valid;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_stale_addr_next;
  logic [31:0] w_skid_next;
  logic [31:0] w_if_id_pc1_next;
  logic [31:0] w_if_id_instr_next;
  logic        w_if_id_valid_next;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus1;

  assign w_redirect = i_branch_taken | i_jump;
  assign w_target   = i_branch_taken ? i_branch_target : i_jump_target;
  assign w_pc_plus1 = r_pc + 32'd1;  // modulo 2^32, wraps silently

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_stale_addr  <= RESET_PC;
      r_skid        <= 32'd0;
      r_if_id_pc1   <= 32'd0;
      r_if_id_instr <= 32'd0;
      r_if_id_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_stale_addr  <= w_stale_addr_next;
      r_skid        <= w_skid_next;
      r_if_id_pc1   <= w_if_id_pc1_next;
      r_if_id_instr <= w_if_id_instr_next;
      r_if_id_valid <= w_if_id_valid_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_stale_addr_next  = r_stale_addr;
    w_skid_next        = r_skid;
    w_if_id_pc1_next   = r_if_id_pc1;
    w_if_id_instr_next = r_if_id_instr;
    // Stall freezes IF/ID; otherwise decode consumes the entry and it becomes
    // a bubble unless a new instruction is loaded below.
    w_if_id_valid_next = i_stall ? r_if_id_valid : 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_state_next = ST_REQ;
        if (w_redirect) begin
          w_pc_next          = w_target;
          w_if_id_valid_next = 1'b0;
        end
      end

      ST_REQ: begin
        if (w_redirect) begin
          // Any response arriving now belongs to the old path and is dropped.
          w_pc_next          = w_target;
          w_if_id_valid_next = 1'b0;
          if (!imem.imem_ack) begin
            // Memory still owns the request: keep presenting the old address.
            w_stale_addr_next = r_pc;
            w_state_next      = ST_DRAIN;
          end
        end else if (imem.imem_ack) begin
          if (!i_stall) begin
            w_if_id_instr_next = imem.imem_rdata;
            w_if_id_pc1_next   = w_pc_plus1;
            w_if_id_valid_next = 1'b1;
            w_pc_next          = w_pc_plus1;
          end else begin
            w_skid_next  = imem.imem_rdata;
            w_state_next = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (w_redirect) begin
          w_pc_next          = w_target;
          w_if_id_valid_next = 1'b0;
          w_state_next       = ST_REQ;
        end else if (!i_stall) begin
          w_if_id_instr_next = r_skid;
          w_if_id_pc1_next   = w_pc_plus1;
          w_if_id_valid_next = 1'b1;
          w_pc_next          = w_pc_plus1;
          w_state_next       = ST_REQ;
        end
      end

      ST_DRAIN: begin
        w_if_id_valid_next = 1'b0;
        if (w_redirect) begin
          w_pc_next = w_target;
        end
        // The stale request retires on ack (its data is dropped). A redirect
        // that lands in the same cycle as that ack has nothing left to drain.
        if (imem.imem_ack) begin
          w_state_next = ST_REQ;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem.imem_req  = (r_state == ST_REQ) || (r_state == ST_DRAIN);
  assign imem.imem_addr = (r_state == ST_DRAIN) ? r_stale_addr : r_pc;

  assign o_if_id_pc1   = r_if_id_pc1;
  assign o_if_id_instr = r_if_id_instr;
  assign o_if_id_valid = r_if_id_valid;

`ifdef FETCH_PERF_CNT_EN
  // Counts only loads that make IF/ID valid; dropped responses never qualify
  // because a redirect suppresses the load in the same cycle.
  logic        w_fetch_load;
  logic [31:0] r_fetch_count;

  assign w_fetch_load = !w_redirect && !i_stall &&
                        (((r_state == ST_REQ) && imem.imem_ack) ||
                         (r_state == ST_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= 32'd0;
    end else if (w_fetch_load) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed self-checking bench for pc_fetch_unit. Expected IF/ID contents are
// queued as stimulus is applied and popped after the clock edge that should
// produce them. A second instance with RESET_PC=0xFFFF_FFFF covers wrap.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_fetch_unit;

  localparam logic [31:0] XORK = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc1;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        tb_ack;

  logic [31:0] if_id_pc1,  if_id_instr;
  logic        if_id_valid;
  logic [31:0] w2_pc1, w2_instr;
  logic        w2_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] fetch_count2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  ifid_t sb[$];

  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();
  pc_fetch_unit_if bus2 ();

  // Memory model: response is address ^ constant; ack under bench control.
  assign bus.imem_ack    = tb_ack;
  assign bus.imem_rdata  = bus.imem_addr ^ XORK;
  assign bus2.imem_ack   = 1'b1;
  assign bus2.imem_rdata = bus2.imem_addr ^ XORK;

  pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .imem            (bus),
    .o_if_id_pc1     (if_id_pc1),
    .o_if_id_instr   (if_id_instr),
    .o_if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_count   (fetch_count)
`endif
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_stall         (1'b0),
    .i_branch_taken  (1'b0),
    .i_branch_target (32'd0),
    .i_jump          (1'b0),
    .i_jump_target   (32'd0),
    .imem            (bus2),
    .o_if_id_pc1     (w2_pc1),
    .o_if_id_instr   (w2_instr),
    .o_if_id_valid   (w2_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_count   (fetch_count2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc1, input logic [31:0] instr);
    ifid_t e;
    e.pc1   = pc1;
    e.instr = instr;
    e.valid = 1'b1;
    sb.push_back(e);
  endtask

  // Advance one clock, then compare any queued IF/ID expectation.
  task automatic tick();
    ifid_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_pc1",   if_id_pc1,   e.pc1);
      chk("sb_instr", if_id_instr, e.instr);
      chk("sb_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
      $display("txn ifid pc1=%h instr=%h valid=%0b", if_id_pc1, if_id_instr, if_id_valid);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    jump          = 1'b0;
    jump_target   = 32'd0;
    tb_ack        = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h100);
    chk("rst_pc1",   if_id_pc1, 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_count", fetch_count, 32'd0);
`endif

    // Release between edges; first request on the next edge
    rst_n = 1'b1;
    tick();
    chk("first_req",   {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr",  bus.imem_addr, 32'h100);
    chk("first_valid", {31'd0, if_id_valid}, 32'd0);
    chk("wrap_addr0",  bus2.imem_addr, 32'hFFFF_FFFF);

    // Streaming with ack tied high
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h101 + i, (32'h100 + i) ^ XORK);
      tick();
      chk("stream_addr", bus.imem_addr, 32'h101 + i);
      if (i == 0) begin
        chk("wrap_pc1",   w2_pc1, 32'h0000_0000);
        chk("wrap_instr", w2_instr, 32'hFFFF_FFFF ^ XORK);
        chk("wrap_addr1", bus2.imem_addr, 32'h0000_0000);
      end
    end

    // Stall while ack at 0x104: HOLD for three edges, IF/ID frozen
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req",   {31'd0, bus.imem_req}, 32'd0);
      chk("hold_pc1",   if_id_pc1, 32'h104);
      chk("hold_instr", if_id_instr, 32'h103 ^ XORK);
      chk("hold_valid", {31'd0, if_id_valid}, 32'd1);
      $display("txn hold cycle %0d req=%0b pc1=%h", i, bus.imem_req, if_id_pc1);
    end
    stall = 1'b0;
    push_exp(32'h105, 32'h104 ^ XORK);
    tick();
    chk("release_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("release_addr", bus.imem_addr, 32'h105);
    push_exp(32'h106, 32'h105 ^ XORK);
    tick();

    // Branch and jump together: branch wins
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    jump          = 1'b1;
    jump_target   = 32'h300;
    tick();
    chk("br_addr",  bus.imem_addr, 32'h200);
    chk("br_valid", {31'd0, if_id_valid}, 32'd0);
    $display("txn branch addr=%h valid=%0b", bus.imem_addr, if_id_valid);
    branch_taken = 1'b0;
    jump         = 1'b0;
    push_exp(32'h201, 32'h200 ^ XORK);
    tick();
`ifdef FETCH_PERF_CNT_EN
    chk("count_7", fetch_count, 32'd7);
`endif

    // DRAIN: jump to 0x40 while the request at 0x201 is not yet acked
    tb_ack      = 1'b0;
    jump        = 1'b1;
    jump_target = 32'h40;
    tick();
    jump = 1'b0;
    chk("drain_req0",  {31'd0, bus.imem_req}, 32'd1);
    chk("drain_addr0", bus.imem_addr, 32'h201);
    chk("drain_valid", {31'd0, if_id_valid}, 32'd0);
    tick();
    chk("drain_addr1", bus.imem_addr, 32'h201);
    tb_ack = 1'b1;
    tick();
    chk("drain_done_addr",  bus.imem_addr, 32'h40);
    chk("drain_done_valid", {31'd0, if_id_valid}, 32'd0);
    $display("txn drain done addr=%h", bus.imem_addr);
    push_exp(32'h41, 32'h40 ^ XORK);
    tick();
`ifdef FETCH_PERF_CNT_EN
    chk("count_8", fetch_count, 32'd8);
`endif

    // Async reset mid-HOLD
    stall = 1'b1;
    tick();
    chk("pre_rst_hold_req", {31'd0, bus.imem_req}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("arst_addr",  bus.imem_addr, 32'h100);
    chk("arst_pc1",   if_id_pc1, 32'd0);
    chk("arst_instr", if_id_instr, 32'd0);
    chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_count", fetch_count, 32'd0);
`endif
    $display("txn async reset req=%0b addr=%h", bus.imem_req, bus.imem_addr);
    #1;
    rst_n = 1'b1;
    stall = 1'b0;
    tick();
    chk("rerun_addr", bus.imem_addr, 32'h100);
    push_exp(32'h101, 32'h100 ^ XORK);
    tick();
`ifdef FETCH_PERF_CNT_EN
    chk("rerun_count", fetch_count, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end of the pipelined processor: owns the program counter, consumes the PC+1 next-address path, issues word-addressed requests to instruction memory and loads the IF/ID pipeline register. It sits between instruction memory and the decode stage. It accepts redirects (branch, jump) and back-pressure (stall) from later stages.

## Interface
- RESET_PC, 32'h0000_0000, word address of the first fetch after reset
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  decode stage cannot accept; freeze IF/ID and PC
- branch_taken  input  1  redirect to branch_target (highest priority)
- branch_target  input  32  branch destination, word address
- jump  input  1  redirect to jump_target (ignored if branch_taken)
- jump_target  input  32  jump destination, word address
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch word address; stable while imem_req=1 until ack
- imem_ack  input  1  response valid this cycle; only meaningful while imem_req=1
- imem_rdata  input  32  instruction word, valid with imem_ack
- if_id_pc1  output  32  address of captured instruction + 1
- if_id_instr  output  32  captured instruction
- if_id_valid  output  1  IF/ID holds a live instruction

## Operation
- One outstanding request max. Memory contract: req and addr held until ack; ack may arrive in the same cycle as req.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: entered on reset; imem_req=0. Next cycle -> REQ.
- REQ: imem_req=1, imem_addr=pc.
  - ack & !stall: if_id_instr<=rdata, if_id_pc1<=pc+1, if_id_valid<=1, pc<=pc+1; stay REQ.
  - ack & stall: rdata -> skid register, pc held; -> HOLD.
  - no ack: stay REQ.
- HOLD: imem_req=0. When stall=0: IF/ID loaded from skid (pc1=pc+1), pc<=pc+1; -> REQ.
- Redirect (branch_taken | jump), any state, overrides stall:
  - pc<=target (branch_target if branch_taken else jump_target); if_id_valid<=0; skid discarded.
  - In REQ without ack: -> DRAIN. Otherwise (REQ with ack, HOLD, IDLE): -> REQ. Any ack data in the redirect cycle is discarded.
- DRAIN: imem_req=1 at the stale address until ack. Data is discarded; -> REQ at the new pc. A further redirect in DRAIN updates pc and stays DRAIN.
- stall with no redirect: IF/ID holds all fields, including if_id_valid.
- Arithmetic: 32-bit modulo. pc 32'hFFFF_FFFF + 1 = 32'h0000_0000, no flag.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, if_id_pc1=0, if_id_instr=0 (NOP), if_id_valid=0, state=IDLE.
- First imem_req=1 in the first clock edge after rst_n deassertion.
- Same-cycle ack, no stall: one instruction per cycle. Ack at edge N means IF/ID is updated and visible after edge N, and imem_addr=pc+1 from that edge.
- Redirect at edge N with no pending stale request: imem_addr=target after edge N; first redirected instruction in IF/ID after the ack edge.
- HOLD release: stall low at edge N loads IF/ID at edge N; the new request is issued after edge N.
- rst_n low mid-operation: immediate return to reset values; any pending request is abandoned. Memory must tolerate a dropped req.

## Configuration
- FETCH_PERF_CNT_EN defined: adds output fetch_count [31:0].
  - Reset 0; increments on every IF/ID load with if_id_valid<=1; wraps modulo 2^32.
  - Discarded (DRAIN or redirect-cycle) responses are not counted.
- Undefined: port, counter and logic are absent; all other behaviour is identical.

## Test plan
- Reset and streaming: RESET_PC=0x100, imem_ack tied 1, rdata=addr^0xA5A5_0000 -> IF/ID pc1 runs 0x101, 0x102, 0x103… on consecutive cycles; valid=1 from the first ack.
- Stall with ack: stall=1 while ack at addr 0x104 for 3 cycles -> HOLD, imem_req=0, IF/ID frozen. After release, IF/ID = {0x105, rdata(0x104)} and the next req is 0x105.
- Branch vs jump: branch_taken=1 to 0x200 and jump=1 to 0x300 in the same cycle -> next imem_addr=0x200, if_id_valid=0.
- DRAIN: ack delayed 2 cycles; jump to 0x40 on the first req cycle -> stale addr held until ack, data discarded, then req at 0x40 and IF/ID pc1=0x41.
- Wrap: RESET_PC=0xFFFF_FFFF -> first IF/ID pc1=0x0000_0000, next imem_addr=0x0.
- Async reset mid-HOLD: rst_n pulsed low between edges -> outputs immediately at reset values; with FETCH_PERF_CNT_EN, fetch_count=0.
